pmod_debouncer: RTL and testbench
=================================

// Module: pmod_debouncer
// PURPOSE
//  Input stage for the button-count logic. Three raw, active-low PMOD button pins
//  enter here and are synchronised and debounced per channel. Clean active-low
//  levels leave on PMOD_OUT, which drives the counter's PMOD1..PMOD3 directly.
//  The block also emits one-cycle press/release strobes and a settled flag.
// PARAMETERS
//  N_CH            3       number of button channels
//  DEBOUNCE_CYCLES 120000  cycles a new level must hold before acceptance (10 ms @ 12 MHz); legal >= 2
//  CNT_W           17      stability counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  CLK            in   1     single system clock; every flop is rising-edge
//  RST            in   1     synchronous, active-high reset
//  PMOD_IN        in   N_CH  raw button pins, active-low, asynchronous to CLK
//  PMOD_OUT       out  N_CH  debounced level, active-low (0 = pressed)
//  PRESS_PULSE    out  N_CH  1-cycle strobe when a channel's PMOD_OUT falls 1->0
//  RELEASE_PULSE  out  N_CH  1-cycle strobe when a channel's PMOD_OUT rises 0->1
//  STABLE         out  1     1 when no channel has a pending (counting) transition
// BEHAVIOUR
//  - Reset (RST high at a rising CLK edge): every output is registered and resets as follows.
//    PMOD_OUT=all 1 (released); PRESS_PULSE=0; RELEASE_PULSE=0; STABLE=1.
//    Both synchroniser stages reset to 1. Stability counters reset to 0. Channel FSMs reset to REL.
//  - Synchroniser: two flops per channel (s1, s2). Only s2 feeds the logic.
//  - Per-channel FSM has four states: REL (out=1), PRESS_WAIT, PRS (out=0), and RELEASE_WAIT.
//    REL: s2==0 -> PRESS_WAIT, cnt<=1; otherwise stay, cnt<=0.
//    PRESS_WAIT: s2==1 (bounce) -> REL, cnt<=0. cnt==DEBOUNCE_CYCLES-1 with s2==0 -> PRS.
//      On that transition PMOD_OUT<=0 and PRESS_PULSE<=1 for exactly one cycle.
//      Otherwise cnt<=cnt+1.
//    PRS / RELEASE_WAIT: mirror image, with s2==1 as the trigger level.
//      On acceptance, PMOD_OUT<=1 and RELEASE_PULSE<=1 for one cycle.
//  - Latency: consider a raw level first sampled into s1 at edge k and held.
//    PMOD_OUT changes at edge k+1+DEBOUNCE_CYCLES. The strobe is high in the cycle after that edge.
//  - Any bounce resets that channel's count to 0. The count never saturates or wraps,
//    because it is cleared on acceptance.
//  - Channels are fully independent. Simultaneous acceptances on several channels assert
//    several strobe bits in the same cycle. PRESS_PULSE and RELEASE_PULSE never share a bit in one cycle.
//  - STABLE is registered. It is 0 in any cycle where some channel is in PRESS_WAIT or RELEASE_WAIT.
//  - RST mid-debounce aborts all pending counts; PMOD_OUT returns to all 1 with no strobes.
//    After reset, a pin held low requires the full latency before PMOD_OUT drops.
//  - Downstream contract: PMOD_OUT changes at most once per DEBOUNCE_CYCLES per channel.
//    The counter's combinational D1/D2 therefore see glitch-free, clock-aligned levels.
// STRUCTURE
//  - Shared package pmod_pkg holds the following items:
//    the 2-bit FSM state typedef (REL=0, PRESS_WAIT=1, PRS=2, RELEASE_WAIT=3);
//    the DEFAULT_DEBOUNCE_CYCLES constant;
//    the BTN_PRESSED=1'b0 polarity constant.
//  - One sub-module, debounce_channel: holds the synchroniser, counter, FSM and strobes for one bit.
//    pmod_debouncer instantiates N_CH of them in a generate loop and ANDs their idle flags into STABLE.
// TESTING  (run with DEBOUNCE_CYCLES=4, CNT_W=3)
//  1. Reset behaviour.
//     Stimulus: PMOD_IN=3'b000 while RST high 3 cycles.
//     Required: PMOD_OUT=3'b111, strobes=0, STABLE=1.
//     After release, PMOD_OUT=3'b000 exactly 5 edges after the first sample.
//  2. Clean press and release.
//     Stimulus: bit0 goes 1->0, held 10 cycles, then back to 1.
//     Required: PRESS_PULSE=3'b001 for exactly 1 cycle; 5 cycles later PMOD_OUT[0]=0.
//     After release, RELEASE_PULSE=3'b001 for 1 cycle, and the level is 1 again.
//  3. Bounce rejection.
//     Stimulus: bit1 toggles 0,0,0,1,0,0,0,1 (each shorter than 4 cycles).
//     Required: PMOD_OUT[1] stays 1, no strobes, STABLE pulses low during the activity.
//  4. Simultaneous events.
//     Stimulus: all three bits fall on the same edge.
//     Required: PRESS_PULSE=3'b111 in a single cycle and PMOD_OUT=3'b000.
//     The counter fed by PMOD_OUT reads D2=1, D1=1.
//  5. Reset mid-debounce.
//     Stimulus: bit2 is low for 2 cycles, then RST is pulsed for 1 cycle.
//     Required: no PRESS_PULSE, PMOD_OUT[2]=1, and the count restarts from 0.
//  6. Mixed directions.
//     Stimulus: bit0 releases and bit2 presses, with both accepted on the same edge.
//     Required: PRESS_PULSE=3'b100 and RELEASE_PULSE=3'b001 in the same cycle.

Source files
------------

// File: rtl/pmod_pkg.sv
// Shared definitions for the PMOD button input stage.
// Contents:
//   deb_state_e             per-channel debounce FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES acceptance hold time (10 ms at 12 MHz)
//   BTN_PRESSED             pin level that means "button pressed"
package pmod_pkg;

  typedef enum logic [1:0] {
    REL          = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRS          = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;

  localparam logic BTN_PRESSED = 1'b0;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: two-flop synchroniser, stability counter,
// four-state acceptance FSM and registered press/release strobes.
// Ports:
//   CLK, RST         rising-edge clock, synchronous active-high reset
//   i_pin            raw active-low pin, asynchronous to CLK
//   o_level          debounced active-low level (0 = pressed)
//   o_pressPulse     1-cycle strobe on accepted press
//   o_releasePulse   1-cycle strobe on accepted release
//   o_idle           1 when no transition is being timed
module debounce_channel
  import pmod_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 17
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_pin,
  output logic o_level,
  output logic o_pressPulse,
  output logic o_releasePulse,
  output logic o_idle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  deb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_idle;

  deb_state_e       w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_levelNext;
  logic             w_pressNext;
  logic             w_releaseNext;

  // Synchroniser. Resets to the released level so a reset never looks like a press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

  // The counter starts at 1 on entry to a WAIT state because the entering sample
  // already counts toward the hold time; acceptance fires on the sample that
  // completes DEBOUNCE_CYCLES consecutive matching samples.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_levelNext   = r_level;
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;
    case (r_state)
      REL: begin
        if (r_s2 == BTN_PRESSED) begin
          w_stateNext = PRESS_WAIT;
          w_cntNext   = CNT_ONE;
        end else begin
          w_cntNext = '0;
        end
      end
      PRESS_WAIT: begin
        if (r_s2 != BTN_PRESSED) begin
          w_stateNext = REL;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = PRS;
          w_cntNext   = '0;
          w_levelNext = BTN_PRESSED;
          w_pressNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      PRS: begin
        if (r_s2 != BTN_PRESSED) begin
          w_stateNext = RELEASE_WAIT;
          w_cntNext   = CNT_ONE;
        end else begin
          w_cntNext = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_s2 == BTN_PRESSED) begin
          w_stateNext = PRS;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext   = REL;
          w_cntNext     = '0;
          w_levelNext   = ~BTN_PRESSED;
          w_releaseNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = REL;
        w_cntNext   = '0;
        w_levelNext = ~BTN_PRESSED;
      end
    endcase
  end

  // State, counter and every output are registered. The idle flag is computed
  // from the next state so it lines up with the cycle the FSM is actually in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= REL;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_level   <= w_levelNext;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
      r_idle    <= (w_stateNext != PRESS_WAIT) && (w_stateNext != RELEASE_WAIT);
    end
  end

  assign o_level        = r_level;
  assign o_pressPulse   = r_press;
  assign o_releasePulse = r_release;
  assign o_idle         = r_idle;

endmodule

// File: rtl/pmod_debouncer.sv
// Input stage for the button-count logic: N_CH raw active-low PMOD pins are
// synchronised and debounced independently.
// Ports:
//   CLK, RST       rising-edge clock, synchronous active-high reset
//   PMOD_IN        raw active-low pins (asynchronous)
//   PMOD_OUT       debounced active-low levels, feed the counter directly
//   PRESS_PULSE    per-channel 1-cycle strobe on accepted press
//   RELEASE_PULSE  per-channel 1-cycle strobe on accepted release
//   STABLE         1 when no channel is timing a transition
module pmod_debouncer
  import pmod_pkg::*;
#(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 17
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] PMOD_IN,
  output logic [N_CH-1:0] PMOD_OUT,
  output logic [N_CH-1:0] PRESS_PULSE,
  output logic [N_CH-1:0] RELEASE_PULSE,
  output logic            STABLE
);

  logic [N_CH-1:0] w_idle;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .CLK            (CLK),
      .RST            (RST),
      .i_pin          (PMOD_IN[g]),
      .o_level        (PMOD_OUT[g]),
      .o_pressPulse   (PRESS_PULSE[g]),
      .o_releasePulse (RELEASE_PULSE[g]),
      .o_idle         (w_idle[g])
    );
  end

  // Each idle flag is a flop, so the AND is a clean function of registered state.
  assign STABLE = &w_idle;

endmodule

// File: tb/tb_pmod_debouncer.sv
// Self-checking bench for pmod_debouncer with DEBOUNCE_CYCLES=4, CNT_W=3.
// The reference model treats each channel as "a pin value delayed by two
// samples, accepted once it has disagreed with the output for D samples in a row".
module tb_pmod_debouncer;

  localparam int D = 4;

  logic       CLK;
  logic       RST;
  logic [2:0] PMOD_IN;
  logic [2:0] PMOD_OUT;
  logic [2:0] PRESS_PULSE;
  logic [2:0] RELEASE_PULSE;
  logic       STABLE;

  int checkCount;
  int errorCount;

  logic [2:0] mP1, mP2, mOut, mPress, mRel;
  logic       mStable;
  int         mRun [3];

  pmod_debouncer #(
    .N_CH            (3),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PMOD_IN       (PMOD_IN),
    .PMOD_OUT      (PMOD_OUT),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .STABLE        (STABLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Model of one clock edge: pins reach the decision logic two edges late.
  task automatic modelStep(input logic [2:0] pin, input logic rst);
    logic [2:0] samp;
    if (rst) begin
      mP1 = 3'b111; mP2 = 3'b111; mOut = 3'b111;
      mPress = 3'b000; mRel = 3'b000; mStable = 1'b1;
      for (int c = 0; c < 3; c++) mRun[c] = 0;
    end else begin
      samp = mP2;
      mP2 = mP1;
      mP1 = pin;
      mPress = 3'b000;
      mRel = 3'b000;
      mStable = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (samp[c] != mOut[c]) begin
          mRun[c]++;
          if (mRun[c] == D) begin
            if (samp[c] == 1'b0) mPress[c] = 1'b1;
            else                 mRel[c]   = 1'b1;
            mOut[c] = samp[c];
            mRun[c] = 0;
          end
        end else begin
          mRun[c] = 0;
        end
        if (mRun[c] != 0) mStable = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, check #1 later.
  task automatic applyStimulus(input logic [2:0] pin, input logic rst);
    PMOD_IN = pin;
    RST = rst;
    @(posedge CLK);
    modelStep(pin, rst);
    #1;
    checkOutput("pmod_out", 32'(PMOD_OUT), 32'(mOut));
    checkOutput("press", 32'(PRESS_PULSE), 32'(mPress));
    checkOutput("release", 32'(RELEASE_PULSE), 32'(mRel));
    checkOutput("stable", 32'(STABLE), 32'(mStable));
  endtask

  task automatic hold(input logic [2:0] pin, input int n);
    for (int i = 0; i < n; i++) applyStimulus(pin, 1'b0);
  endtask

  initial begin
    logic [2:0] pin;
    logic [7:0] bouncePat;
    int hits;
    checkCount = 0;
    errorCount = 0;
    PMOD_IN = 3'b000;
    RST = 1'b1;

    // Reset with all pins low, then exact latency of the first press.
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b1);
    checkOutput("reset_out", 32'(PMOD_OUT), 32'h7);
    checkOutput("reset_stable", 32'(STABLE), 32'h1);
    hold(3'b000, 5);
    checkOutput("latency_edge5", 32'(PMOD_OUT), 32'h7);
    hits = 0;
    applyStimulus(3'b000, 1'b0);
    checkOutput("latency_edge6", 32'(PMOD_OUT), 32'h0);
    if (PRESS_PULSE == 3'b111) hits++;
    hold(3'b000, 1);
    checkOutput("press_all_once", 32'(hits), 32'd1);
    hold(3'b111, 10);

    // Clean press and release on bit 0.
    hold(3'b110, 10);
    checkOutput("bit0_pressed", 32'(PMOD_OUT), 32'h6);
    hold(3'b111, 10);
    checkOutput("bit0_released", 32'(PMOD_OUT), 32'h7);

    // Bounce on bit 1: runs of three never reach the hold time.
    bouncePat = 8'b1000_1000;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        pin = 3'b111;
        pin[1] = bouncePat[i];
        applyStimulus(pin, 1'b0);
        checkOutput("bounce_level", 32'(PMOD_OUT[1]), 32'h1);
      end
    hold(3'b111, 6);

    // Simultaneous press on all channels.
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b000, 1'b0);
      if (PRESS_PULSE == 3'b111) hits++;
    end
    checkOutput("simul_press_count", 32'(hits), 32'd1);
    checkOutput("simul_out", 32'(PMOD_OUT), 32'h0);
    hold(3'b111, 8);

    // Reset in the middle of a pending press on bit 2.
    hold(3'b011, 2);
    applyStimulus(3'b011, 1'b1);
    checkOutput("midreset_out", 32'(PMOD_OUT), 32'h7);
    hold(3'b011, 5);
    checkOutput("midreset_restart", 32'(PMOD_OUT), 32'h7);
    hold(3'b011, 1);
    checkOutput("midreset_accept", 32'(PMOD_OUT), 32'h3);
    hold(3'b111, 8);

    // Bit 0 releases while bit 2 presses, accepted on the same edge.
    hold(3'b110, 8);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b011, 1'b0);
      if (PRESS_PULSE == 3'b100 && RELEASE_PULSE == 3'b001) hits++;
    end
    checkOutput("mixed_same_cycle", 32'(hits), 32'd1);
    checkOutput("mixed_out", 32'(PMOD_OUT), 32'h3);

    // Random pin activity with occasional resets.
    pin = 3'b111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) pin[$urandom_range(0, 2)] ^= 1'b1;
      applyStimulus(pin, ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
